fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/pc_next.sv | 51 +++++
 rtl/fetch_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the instruction fetch controller.
package fetch_pkg;

    localparam int PSIZE_DEF = 6;
    localparam int ISIZE_DEF = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    // Next-pc source, chosen by the fetch FSM and applied inside pc_next.
    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_LOAD = 2'd2,
        PC_ZERO = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/pc_next.sv
// Program counter register with its next-value mux and branch target adder.
module pc_next
    import fetch_pkg::*;
#(
    parameter int Psize = PSIZE_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [1:0]       sel_i,
    input  logic             br_abs_i,
    input  logic [Psize-1:0] br_addr_i,
    input  logic [Psize-1:0] instr_pc_i,
    output logic [Psize-1:0] target_o,
    output logic [Psize-1:0] pc_o
);

    localparam logic [Psize-1:0] ONE = {{(Psize-1){1'b0}}, 1'b1};

    logic [Psize-1:0] pc_q;
    logic [Psize-1:0] pc_d;
    logic [Psize-1:0] target;

    // At equal width, a modulo-2^Psize add of the raw offset is the same as
    // adding its sign-extended value, so no explicit extension is needed.
    always_comb begin
        target = br_abs_i ? br_addr_i : (instr_pc_i + br_addr_i);
    end

    always_comb begin
        pc_d = pc_q;
        case (pc_sel_e'(sel_i))
            PC_HOLD: pc_d = pc_q;
            PC_INC:  pc_d = pc_q + ONE;
            PC_LOAD: pc_d = target;
            PC_ZERO: pc_d = '0;
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign target_o = target;
    assign pc_o     = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: IDLE/RUN/HALT FSM, instruction register and branch bubble.
// Define FETCH_SELFLOOP_HALT_EN to turn a branch-to-self into a halt.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int Psize = PSIZE_DEF,
    parameter int Isize = ISIZE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             br_abs,
    input  logic             br_rel,
    input  logic [Psize-1:0] br_addr,
    output logic [Psize-1:0] mem_addr,
    input  logic [Isize:0]   mem_data,
    output logic [Isize:0]   instr,
    output logic [Psize-1:0] instr_pc,
    output logic             instr_valid,
    output logic             running,
    output logic             halted,
    output logic [1:0]       state_dbg
);

`ifdef FETCH_SELFLOOP_HALT_EN
    localparam bit SELFLOOP_HALT = 1'b1;
`else
    localparam bit SELFLOOP_HALT = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [Isize:0]   instr_q, instr_d;
    logic [Psize-1:0] instr_pc_q, instr_pc_d;
    logic             valid_q, valid_d;
    pc_sel_e          pc_sel;
    logic [Psize-1:0] pc;
    logic [Psize-1:0] target;

    pc_next #(
        .Psize(Psize)
    ) u_pc_next (
        .clk_i      (clk),
        .rst_ni     (reset),
        .sel_i      (pc_sel),
        .br_abs_i   (br_abs),
        .br_addr_i  (br_addr),
        .instr_pc_i (instr_pc_q),
        .target_o   (target),
        .pc_o       (pc)
    );

    // Stall beats everything; halt and branch act only on a valid instruction,
    // and halt is checked before branch.
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        pc_sel     = PC_HOLD;
        case (state_q)
            IDLE, HALT: begin
                valid_d = 1'b0;
                if (start) begin
                    state_d = RUN;
                    pc_sel  = PC_ZERO;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (valid_q && halt_req) begin
                        state_d = HALT;
                        valid_d = 1'b0;
                    end else if (valid_q && (br_abs || br_rel)) begin
                        valid_d = 1'b0;
                        if (SELFLOOP_HALT && (target == instr_pc_q)) begin
                            state_d = HALT;
                        end else begin
                            pc_sel = PC_LOAD;
                        end
                    end else begin
                        instr_d    = mem_data;
                        instr_pc_d = pc;
                        valid_d    = 1'b1;
                        pc_sel     = PC_INC;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
        end
    end

    assign mem_addr    = pc;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign running     = (state_q == RUN);
    assign halted      = (state_q == HALT);
    assign state_dbg   = state_q;

endmodule
